// File: rtl/ea_mon_pkg.sv
// Shared types and width defaults for the event-capture monitor.
// Contents: trigger-mode enum, default bus widths, packed event width helper.
// Imported by event_capture; carries no logic of its own.
package ea_mon_pkg;

  typedef enum logic [1:0] {
    TRIG_MATCH  = 2'd0,
    TRIG_CHANGE = 2'd1,
    TRIG_RISE   = 2'd2,
    TRIG_RSVD   = 2'd3
  } trig_mode_e;

  localparam int PROBE_W_DEF    = 32;
  localparam int ID_W_DEF       = 8;
  localparam int TS_W_DEF       = 32;
  localparam int FIFO_DEPTH_DEF = 16;

  // Event word is {ts, id, probe}, timestamp in the MSBs.
  function automatic int evt_w(input int ts_w, input int id_w, input int probe_w);
    return ts_w + id_w + probe_w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data updated on each accepted pop.
// Latency: push visible in count/empty/full next cycle; popped head on rd_dat_o next cycle.
// Backpressure: push dropped when full unless a pop is accepted the same cycle; pop on empty ignored.
// Ports: clk/rst (sync, active-high), push_i/push_dat_i, pop_i, rd_dat_o, count_o, empty_o, full_o.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               push_dat_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rd_dat_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           empty_o,
  output logic                           full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rd_dat_q;
  logic             rd_en;
  logic             wr_en;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CW'(DEPTH));
  assign count_o  = count_q;
  assign rd_dat_o = rd_dat_q;

  assign rd_en = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign wr_en = push_i && (!full_o || rd_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_dat_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rd_dat_q <= mem_q[rd_ptr_q];
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // When full, wr_ptr == rd_ptr; the read above sees the old entry before this write lands.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/event_capture.sv
// Probe capture engine: masked trigger evaluation, timestamp/ID stamping, event FIFO.
// Latency: capture in cycle N is counted from N+1; pop in N shows evt_data from N+1.
// Backpressure: captures while full with no pop are dropped and flagged in the overflow sticky.
// Ports: clk/rst, probe, en/arm, trig_mode/value/mask, evt_pop, evt_data/evt_valid, FIFO status, stickies.
module event_capture
  import ea_mon_pkg::*;
#(
  parameter int PROBE_W    = PROBE_W_DEF,
  parameter int ID_W       = ID_W_DEF,
  parameter int TS_W       = TS_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [PROBE_W-1:0]                     probe,
  input  logic                                   en,
  input  logic                                   arm,
  input  logic [1:0]                             trig_mode,
  input  logic [PROBE_W-1:0]                     trig_value,
  input  logic [PROBE_W-1:0]                     trig_mask,
  input  logic                                   evt_pop,
  output logic [evt_w(TS_W, ID_W, PROBE_W)-1:0]  evt_data,
  output logic                                   evt_valid,
  output logic                                   fifo_empty,
  output logic                                   fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifo_count,
  output logic                                   triggered_sticky,
  output logic                                   fifo_overflow_sticky
);

  localparam int EW = evt_w(TS_W, ID_W, PROBE_W);

  logic               en_q;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [PROBE_W-1:0] probe_prev_q;
  logic               match_prev_q, match_prev_d;
  logic               trig_sticky_q, trig_sticky_d;
  logic               ovf_sticky_q, ovf_sticky_d;

  logic               en_rise;
  logic               match;
  logic               qualify;
  logic               capture;
  logic               pop_acc;
  logic               push_acc;
  logic               overflow;
  logic [EW-1:0]      push_word;

  assign en_rise = en && !en_q;
  assign match   = (((probe ^ trig_value) & trig_mask) == '0);

  always_comb begin
    qualify = 1'b0;
    case (trig_mode_e'(trig_mode))
      TRIG_MATCH:  qualify = match;
      TRIG_CHANGE: qualify = (((probe ^ probe_prev_q) & trig_mask) != '0);
      TRIG_RISE:   qualify = match && !match_prev_q;
      default:     qualify = 1'b0;
    endcase
  end

  assign capture   = en && arm && qualify;
  assign pop_acc   = evt_pop && !fifo_empty;
  assign push_acc  = capture && (!fifo_full || pop_acc);
  assign overflow  = capture && fifo_full && !pop_acc;
  assign push_word = {ts_q, id_q, probe};

  always_comb begin
    ts_d          = ts_q;
    id_d          = id_q;
    match_prev_d  = en ? match : 1'b0;
    trig_sticky_d = trig_sticky_q;
    ovf_sticky_d  = ovf_sticky_q;

    if (en_rise) begin
      ts_d = '0;
    end else if (en) begin
      ts_d = ts_q + 1'b1;
    end

    // The pushed word already carries the old id; the rising edge restarts numbering.
    if (en_rise) begin
      id_d = '0;
    end else if (push_acc) begin
      id_d = id_q + 1'b1;
    end

    // Set wins over the enable-edge clear.
    if (capture) begin
      trig_sticky_d = 1'b1;
    end else if (en_rise) begin
      trig_sticky_d = 1'b0;
    end

    if (overflow) begin
      ovf_sticky_d = 1'b1;
    end else if (en_rise) begin
      ovf_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q          <= 1'b0;
      ts_q          <= '0;
      id_q          <= '0;
      probe_prev_q  <= '0;
      match_prev_q  <= 1'b0;
      trig_sticky_q <= 1'b0;
      ovf_sticky_q  <= 1'b0;
    end else begin
      en_q          <= en;
      ts_q          <= ts_d;
      id_q          <= id_d;
      probe_prev_q  <= probe;
      match_prev_q  <= match_prev_d;
      trig_sticky_q <= trig_sticky_d;
      ovf_sticky_q  <= ovf_sticky_d;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push_acc),
    .push_dat_i (push_word),
    .pop_i      (evt_pop),
    .rd_dat_o   (evt_data),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  assign evt_valid            = !fifo_empty;
  assign triggered_sticky     = trig_sticky_q;
  assign fifo_overflow_sticky = ovf_sticky_q;

endmodule
